opb_register_bank_ppc2simulink: RTL and testbench
=================================================

Name: opb_register_bank_ppc2simulink

Overview:
Parametrised successor to the single software register. One OPB slave exposes C_NUM_REGS 32-bit PPC-writable registers to the Simulink fabric, with byte-enable writes, readback and per-register write strobes. The bank sits on the OPB bus with one C_BASEADDR/C_HIGHADDR window. All user-side outputs are in the OPB_Clk domain.

Parameters:
C_BASEADDR, 32'hFFFFFFFF, window base; word-aligned, 256-byte aligned
C_HIGHADDR, 32'h00000000, window top (inclusive); window must be at least 4*(C_NUM_REGS+1) bytes
C_OPB_AWIDTH, 32, OPB address width
C_OPB_DWIDTH, 32, OPB data width; only 32 is supported
C_NUM_REGS, 8, number of user registers, 1..64
C_RESET_VAL, 32'h00000000, reset value loaded into every register
C_FAMILY, "virtex5", carried for tool flow; no functional effect

Ports:
OPB_Clk  in  1  single clock for bus and user side
OPB_Rst  in  1  asynchronous, active-high reset
OPB_ABus  in  [0:31]  address
OPB_BE  in  [0:3]  byte enables; BE[0] selects DBus[0:7]
OPB_DBus  in  [0:31]  write data
OPB_RNW  in  1  1 = read, 0 = write
OPB_select  in  1  transfer request
OPB_seqAddr  in  1  ignored; every beat is handled as a single transfer
Sl_DBus  out  [0:31]  read data; zero whenever Sl_xferAck=0
Sl_xferAck  out  1  one-cycle transfer acknowledge
Sl_errAck, Sl_retry, Sl_toutSup  out  1 each  constant 0
user_data_out  out  [32*C_NUM_REGS-1:0]  register i occupies bits [32i+31:32i]
user_wr_stb  out  [C_NUM_REGS-1:0]  bit i pulses 1 cycle when register i's output changes

Behaviour:
- Bit mapping: OPB_DBus[k] maps to user bit 31-k. BE[0] maps to user bits 31:24, BE[3] to 7:0.
- Hit condition: OPB_select=1 and C_BASEADDR <= ABus <= C_HIGHADDR.
- Word index = (ABus - C_BASEADDR) >> 2.
- FSM states: IDLE, ACK, HOLD.
  - IDLE -> ACK on a registered hit. The hit and the bus inputs are captured in cycle 1.
  - ACK: Sl_xferAck=1 for exactly one cycle (cycle 2). For reads, Sl_DBus is driven in this cycle. For writes, the selected bytes are written at the end of this cycle.
  - ACK -> HOLD unconditionally.
  - HOLD -> IDLE unconditionally. HOLD blocks a re-ack while the master deasserts select.
- Latency: select to xferAck = 2 cycles. Minimum back-to-back transfer spacing = 3 cycles.
- Write data: user_data_out reflects new data in cycle 3. user_wr_stb[i]=1 in cycle 3 only, and only if at least one BE bit is set.
- Write with BE=0000: acked, no data change, no strobe.
- Index >= C_NUM_REGS, but still inside the window (no commit register present): reads return 0; writes are acked and ignored.
- An address outside the window is never acked. Sl_DBus stays 0 so the wired-OR bus is not disturbed.
- OPB_select dropped during ACK: the ack still completes and the write is still committed.
- OPB_Rst asserted at any point:
  - FSM goes to IDLE and Sl_* go to 0 immediately (asynchronous).
  - All registers load C_RESET_VAL.
  - user_wr_stb goes to 0.
  - A transfer in flight is lost.
- Reset values: Sl_DBus=0, Sl_xferAck=0, user_data_out={C_NUM_REGS{C_RESET_VAL}}, user_wr_stb=0.

Optional Feature:
Macro: OPB_REG_BANK_SHADOW_COMMIT_EN.
- Defined:
  - Writes land in shadow registers. Readback at index < C_NUM_REGS returns shadow contents.
  - A commit register sits at index C_NUM_REGS. A write to it with BE[3]=1 and DBus[31]=1 copies all shadows to user_data_out in one cycle (cycle 3).
  - In that cycle, user_wr_stb pulses for every register whose shadow was written since the last commit. Those per-register dirty flags are cleared at the same time.
  - A read of the commit register returns {31'b0, any_dirty}.
  - Reset clears the dirty flags and loads C_RESET_VAL into both shadows and outputs.
- Undefined: writes go directly to user_data_out. Index C_NUM_REGS reads as 0.

Test Plan:
- Reset, then read indices 0..7 with C_RESET_VAL=32'h0000_00A5 -> each returns DBus=32'h0000_00A5 two cycles after select; user_wr_stb=0.
- Write 32'h1234_5678 to index 3 with BE=1111 -> xferAck in cycle 2; user_data_out[127:96]=32'h1234_5678 and user_wr_stb=8'b0000_1000 in cycle 3; other registers unchanged.
- Write 32'hFFFF_FFFF to index 3 with BE=0100 over 32'h1234_5678 -> register=32'h12FF_5678, strobe bit 3 pulses; a later write with BE=0000 -> acked, no strobe.
- Held select, plus an address one beyond the window -> exactly one ack per 3 cycles for the held select; zero acks and Sl_DBus=0 for the out-of-window address.
- Assert OPB_Rst during cycle 2 of a write -> Sl_xferAck drops immediately; register keeps C_RESET_VAL; FSM accepts a new transfer right after reset releases.
- With SHADOW_COMMIT_EN: write indices 1 and 5, user_data_out stays unchanged; commit register reads 1; commit write -> both outputs update in the same cycle, user_wr_stb=8'b0010_0010, commit register then reads 0.

Source files
------------

// File: rtl/opb_register_bank_ppc2simulink_if.sv
// OPB slave signal bundle for the PPC-to-Simulink register bank.
// Vectors keep OPB big-endian numbering: bit 0 is the most significant bit.
interface opb_register_bank_ppc2simulink_if #(
  parameter int C_OPB_AWIDTH = 32,
  parameter int C_OPB_DWIDTH = 32
);
  logic [0:C_OPB_AWIDTH-1]   OPB_ABus;
  logic [0:C_OPB_DWIDTH/8-1] OPB_BE;
  logic [0:C_OPB_DWIDTH-1]   OPB_DBus;
  logic                      OPB_RNW;
  logic                      OPB_select;
  logic                      OPB_seqAddr;
  logic [0:C_OPB_DWIDTH-1]   Sl_DBus;
  logic                      Sl_xferAck;
  logic                      Sl_errAck;
  logic                      Sl_retry;
  logic                      Sl_toutSup;

  modport master (
    output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );

  modport slave (
    input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );
endinterface

// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave exposing C_NUM_REGS PPC-writable 32-bit registers to the fabric.
// Define OPB_REG_BANK_SHADOW_COMMIT_EN for shadow registers plus a commit register.
module opb_register_bank_ppc2simulink #(
  parameter logic [31:0] C_BASEADDR   = 32'hFFFF_FFFF,
  parameter logic [31:0] C_HIGHADDR   = 32'h0000_0000,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int          C_NUM_REGS   = 8,
  parameter logic [31:0] C_RESET_VAL  = 32'h0000_0000,
  parameter              C_FAMILY     = "virtex5"
) (
  input  logic                              OPB_Clk,
  input  logic                              OPB_Rst,
  opb_register_bank_ppc2simulink_if.slave   opb,
  output logic [32*C_NUM_REGS-1:0]          user_data_out,
  output logic [C_NUM_REGS-1:0]             user_wr_stb
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACK  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam int IDX_W = (C_NUM_REGS > 1) ? $clog2(C_NUM_REGS) : 1;
  localparam logic [C_OPB_AWIDTH-1:0] BASE    = C_OPB_AWIDTH'(C_BASEADDR);
  localparam logic [C_OPB_AWIDTH-1:0] HIGH    = C_OPB_AWIDTH'(C_HIGHADDR);
  localparam logic [C_OPB_AWIDTH-3:0] NUM_IDX = (C_OPB_AWIDTH-2)'(C_NUM_REGS);
  // Device family only travels with the netlist for the tool flow.
  localparam int unused_family_bits = $bits(C_FAMILY);

  logic [C_OPB_AWIDTH-1:0]   abus;
  logic [C_OPB_AWIDTH-1:0]   offset;
  logic [C_OPB_AWIDTH-3:0]   word_idx;
  logic [C_OPB_DWIDTH-1:0]   bus_wdata;
  logic [C_OPB_DWIDTH/8-1:0] bus_be;
  logic                      hit;

  logic [1:0]       state_q, state_d;
  logic             rnw_q, rnw_d;
  logic             reg_hit_q, reg_hit_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      out_q [C_NUM_REGS];
  logic [31:0]      out_d [C_NUM_REGS];
  logic [C_NUM_REGS-1:0] stb_q, stb_d;
  logic [31:0]      rd_word;
`ifdef OPB_REG_BANK_SHADOW_COMMIT_EN
  logic             cmt_hit_q, cmt_hit_d;
  logic [31:0]      shadow_q [C_NUM_REGS];
  logic [31:0]      shadow_d [C_NUM_REGS];
  logic [C_NUM_REGS-1:0] dirty_q, dirty_d;
`endif

  // Reversed ranges make OPB bit k land on user bit 31-k and BE[0] on bits 31:24.
  assign abus      = opb.OPB_ABus;
  assign bus_wdata = opb.OPB_DBus;
  assign bus_be    = opb.OPB_BE;
  assign offset    = abus - BASE;
  assign word_idx  = offset[C_OPB_AWIDTH-1:2];
  assign hit       = opb.OPB_select && (abus >= BASE) && (abus <= HIGH);

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    merge_bytes = old_w;
    for (int b = 0; b < 4; b++)
      if (be[b]) merge_bytes[8*b +: 8] = new_w[8*b +: 8];
  endfunction

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    rnw_d     = rnw_q;
    reg_hit_d = reg_hit_q;
    idx_d     = idx_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
`ifdef OPB_REG_BANK_SHADOW_COMMIT_EN
    cmt_hit_d = cmt_hit_q;
`endif
    case (state_q)
      ST_IDLE: begin
        rnw_d     = opb.OPB_RNW;
        reg_hit_d = (word_idx < NUM_IDX);
        idx_d     = word_idx[IDX_W-1:0];
        be_d      = bus_be;
        wdata_d   = bus_wdata;
`ifdef OPB_REG_BANK_SHADOW_COMMIT_EN
        cmt_hit_d = (word_idx == NUM_IDX);
`endif
        if (hit) state_d = ST_ACK;
      end
      ST_ACK:  state_d = ST_HOLD;
      default: state_d = ST_IDLE;
    endcase
  end

  // Write commit happens at the end of the ack cycle, visible one cycle later.
  always_comb begin
    out_d = out_q;
    stb_d = '0;
`ifdef OPB_REG_BANK_SHADOW_COMMIT_EN
    shadow_d = shadow_q;
    dirty_d  = dirty_q;
`endif
    if (state_q == ST_ACK && !rnw_q) begin
      if (reg_hit_q && (be_q != 4'b0000)) begin
`ifdef OPB_REG_BANK_SHADOW_COMMIT_EN
        shadow_d[idx_q] = merge_bytes(shadow_q[idx_q], wdata_q, be_q);
        dirty_d[idx_q]  = 1'b1;
`else
        out_d[idx_q] = merge_bytes(out_q[idx_q], wdata_q, be_q);
        stb_d[idx_q] = 1'b1;
`endif
      end
`ifdef OPB_REG_BANK_SHADOW_COMMIT_EN
      if (cmt_hit_q && be_q[0] && wdata_q[0]) begin
        out_d   = shadow_q;
        stb_d   = dirty_q;
        dirty_d = '0;
      end
`endif
    end
  end

  always_comb begin
    rd_word = '0;
`ifdef OPB_REG_BANK_SHADOW_COMMIT_EN
    if (reg_hit_q)      rd_word = shadow_q[idx_q];
    else if (cmt_hit_q) rd_word = {31'b0, |dirty_q};
`else
    if (reg_hit_q)      rd_word = out_q[idx_q];
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      state_q   <= ST_IDLE;
      rnw_q     <= 1'b0;
      reg_hit_q <= 1'b0;
      idx_q     <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      stb_q     <= '0;
      // NOTE: the bank is discrete flops, not RAM, so each entry resets individually.
      for (int i = 0; i < C_NUM_REGS; i++) out_q[i] <= C_RESET_VAL;
`ifdef OPB_REG_BANK_SHADOW_COMMIT_EN
      cmt_hit_q <= 1'b0;
      dirty_q   <= '0;
      for (int i = 0; i < C_NUM_REGS; i++) shadow_q[i] <= C_RESET_VAL;
`endif
    end else begin
      state_q   <= state_d;
      rnw_q     <= rnw_d;
      reg_hit_q <= reg_hit_d;
      idx_q     <= idx_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      stb_q     <= stb_d;
      out_q     <= out_d;
`ifdef OPB_REG_BANK_SHADOW_COMMIT_EN
      cmt_hit_q <= cmt_hit_d;
      dirty_q   <= dirty_d;
      shadow_q  <= shadow_d;
`endif
    end
  end

  for (genvar i = 0; i < C_NUM_REGS; i++) begin : g_out
    assign user_data_out[32*i +: 32] = out_q[i];
  end
  assign user_wr_stb = stb_q;

  // Read data stays zero outside the ack so the wired-OR bus is undisturbed.
  assign opb.Sl_DBus    = (state_q == ST_ACK && rnw_q) ? rd_word : '0;
  assign opb.Sl_xferAck = (state_q == ST_ACK);
  assign opb.Sl_errAck  = 1'b0;
  assign opb.Sl_retry   = 1'b0;
  assign opb.Sl_toutSup = 1'b0;

  logic unused_inputs;
  assign unused_inputs = ^{opb.OPB_seqAddr, offset[1:0]};

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Directed bench for opb_register_bank_ppc2simulink; expectations follow the
// OPB_REG_BANK_SHADOW_COMMIT_EN setting of the build.
module tb_opb_register_bank_ppc2simulink;

  localparam logic [31:0] BASE    = 32'h8000_0000;
  localparam logic [31:0] HIGH    = 32'h8000_00FF;
  localparam logic [31:0] RST_VAL = 32'h0000_00A5;
  localparam int          N       = 8;
`ifdef OPB_REG_BANK_SHADOW_COMMIT_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [32*N-1:0] user_data_out;
  logic [N-1:0]    user_wr_stb;
  int total = 0;
  int bad   = 0;
  logic [31:0] exp_r [N];
  logic [8:0]  ack_mask;

  opb_register_bank_ppc2simulink_if #(.C_OPB_AWIDTH(32), .C_OPB_DWIDTH(32)) bus ();

  opb_register_bank_ppc2simulink #(
    .C_BASEADDR  (BASE),
    .C_HIGHADDR  (HIGH),
    .C_OPB_AWIDTH(32),
    .C_OPB_DWIDTH(32),
    .C_NUM_REGS  (N),
    .C_RESET_VAL (RST_VAL),
    .C_FAMILY    ("virtex5")
  ) dut (
    .OPB_Clk      (clk),
    .OPB_Rst      (rst),
    .opb          (bus.slave),
    .user_data_out(user_data_out),
    .user_wr_stb  (user_wr_stb)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] packed_exp();
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[32*i +: 32] = exp_r[i];
    return v;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic bus_idle();
    bus.OPB_select  = 1'b0;
    bus.OPB_ABus    = '0;
    bus.OPB_BE      = '0;
    bus.OPB_DBus    = '0;
    bus.OPB_RNW     = 1'b0;
    bus.OPB_seqAddr = 1'b0;
  endtask

  task automatic drive(input logic [31:0] a, input logic rnw, input logic [3:0] be,
                       input logic [31:0] d);
    bus.OPB_ABus   = a;
    bus.OPB_RNW    = rnw;
    bus.OPB_BE     = be;
    bus.OPB_DBus   = d;
    bus.OPB_select = 1'b1;
  endtask

  // Cycle 1 = drive, cycle 2 = ack/read data, cycle 3 = user side update.
  task automatic xfer(input string tag, input logic [31:0] a, input logic rnw,
                      input logic [3:0] be, input logic [31:0] d, input logic exp_ack,
                      input logic [31:0] exp_rd, input logic [N-1:0] exp_stb);
    drive(a, rnw, be, d);
    @(negedge clk);
    check({tag, " ack"}, 256'(bus.Sl_xferAck), 256'(exp_ack));
    check({tag, " dbus"}, 256'(bus.Sl_DBus), 256'(exp_rd));
    bus_idle();
    @(negedge clk);
    check({tag, " ack_once"}, 256'(bus.Sl_xferAck), 256'(1'b0));
    check({tag, " data"}, 256'(user_data_out), packed_exp());
    check({tag, " stb"}, 256'(user_wr_stb), 256'(exp_stb));
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus_idle();
    for (int i = 0; i < N; i++) exp_r[i] = RST_VAL;
    repeat (3) @(negedge clk);
    check("reset ack", 256'(bus.Sl_xferAck), 256'(1'b0));
    check("reset dbus", 256'(bus.Sl_DBus), 256'(32'h0));
    check("reset data", 256'(user_data_out), packed_exp());
    check("reset stb", 256'(user_wr_stb), 256'(8'h00));
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < N; i++)
      xfer($sformatf("rd_reset%0d", i), BASE + 32'(4*i), 1'b1, 4'b1111, 32'h0,
           1'b1, RST_VAL, 8'h00);

    exp_r[3] = SHADOW ? RST_VAL : 32'h1234_5678;
    xfer("wr3_full", BASE + 32'd12, 1'b0, 4'b1111, 32'h1234_5678, 1'b1, 32'h0,
         SHADOW ? 8'h00 : 8'h08);
    exp_r[3] = SHADOW ? RST_VAL : 32'h12FF_5678;
    xfer("wr3_be0100", BASE + 32'd12, 1'b0, 4'b0100, 32'hFFFF_FFFF, 1'b1, 32'h0,
         SHADOW ? 8'h00 : 8'h08);
    xfer("rd3", BASE + 32'd12, 1'b1, 4'b1111, 32'h0, 1'b1, 32'h12FF_5678, 8'h00);
    xfer("wr3_be0000", BASE + 32'd12, 1'b0, 4'b0000, 32'hDEAD_BEEF, 1'b1, 32'h0, 8'h00);
    xfer("rd3_after_be0", BASE + 32'd12, 1'b1, 4'b1111, 32'h0, 1'b1, 32'h12FF_5678, 8'h00);

    xfer("rd_idx8", BASE + 32'd32, 1'b1, 4'b1111, 32'h0, 1'b1,
         SHADOW ? 32'h1 : 32'h0, 8'h00);
    xfer("wr_idx9", BASE + 32'd36, 1'b0, 4'b1111, 32'hCAFE_F00D, 1'b1, 32'h0, 8'h00);
    xfer("rd_idx9", BASE + 32'd36, 1'b1, 4'b1111, 32'h0, 1'b1, 32'h0, 8'h00);
    xfer("rd_above_window", HIGH + 32'd1, 1'b1, 4'b1111, 32'h0, 1'b0, 32'h0, 8'h00);
    xfer("wr_below_window", BASE - 32'd4, 1'b0, 4'b1111, 32'hFFFF_FFFF, 1'b0, 32'h0, 8'h00);

    // Held select: acks land on samples 0, 3 and 6.
    ack_mask = '0;
    drive(BASE, 1'b1, 4'b1111, 32'h0);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      ack_mask[k] = bus.Sl_xferAck;
    end
    bus_idle();
    check("held ack pattern", 256'(ack_mask), 256'(9'b001_001_001));
    @(negedge clk);
    check("held release", 256'(bus.Sl_xferAck), 256'(1'b0));
    repeat (2) @(negedge clk);

    // Reset in the ack cycle of a write.
    drive(BASE + 32'd8, 1'b0, 4'b1111, 32'hDEAD_BEEF);
    @(negedge clk);
    check("rst_mid ack_before", 256'(bus.Sl_xferAck), 256'(1'b1));
    rst = 1'b1;
    #1;
    check("rst_mid ack_drop", 256'(bus.Sl_xferAck), 256'(1'b0));
    bus_idle();
    @(negedge clk);
    for (int i = 0; i < N; i++) exp_r[i] = RST_VAL;
    check("rst_mid data", 256'(user_data_out), packed_exp());
    check("rst_mid stb", 256'(user_wr_stb), 256'(8'h00));
    rst = 1'b0;
    xfer("post_rst_rd2", BASE + 32'd8, 1'b1, 4'b1111, 32'h0, 1'b1, RST_VAL, 8'h00);

`ifdef OPB_REG_BANK_SHADOW_COMMIT_EN
    xfer("sh_wr1", BASE + 32'd4, 1'b0, 4'b1111, 32'h1111_1111, 1'b1, 32'h0, 8'h00);
    xfer("sh_wr5", BASE + 32'd20, 1'b0, 4'b1111, 32'h5555_5555, 1'b1, 32'h0, 8'h00);
    xfer("sh_rd_commit", BASE + 32'd32, 1'b1, 4'b1111, 32'h0, 1'b1, 32'h1, 8'h00);
    xfer("sh_rd1", BASE + 32'd4, 1'b1, 4'b1111, 32'h0, 1'b1, 32'h1111_1111, 8'h00);
    exp_r[1] = 32'h1111_1111;
    exp_r[5] = 32'h5555_5555;
    xfer("sh_commit", BASE + 32'd32, 1'b0, 4'b0001, 32'h0000_0001, 1'b1, 32'h0, 8'b0010_0010);
    xfer("sh_rd_commit_clr", BASE + 32'd32, 1'b1, 4'b1111, 32'h0, 1'b1, 32'h0, 8'h00);
`else
    exp_r[1] = 32'hAA00_00A5;
    xfer("wr1_be1000", BASE + 32'd4, 1'b0, 4'b1000, 32'hAABB_CCDD, 1'b1, 32'h0, 8'h02);
    exp_r[5] = 32'h0000_0044;
    xfer("wr5_be0001", BASE + 32'd20, 1'b0, 4'b0001, 32'h1122_3344, 1'b1, 32'h0, 8'h20);
    xfer("rd5", BASE + 32'd20, 1'b1, 4'b1111, 32'h0, 1'b1, 32'h0000_0044, 8'h00);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
